lock_ctrl: RTL and testbench

// - Sequencing controller for the combination lock: collects keypad digits,

---
 rtl/lock_pkg.sv | 27 ++
 rtl/lock_timer.sv | 37 +++
 rtl/lock_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lock_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared constants for the combination-lock controller: FSM state codes,
// special keypad codes and small arithmetic helpers.
package lock_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_SETPW   = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    localparam logic [3:0] KEY_ENTER   = 4'd10;
    localparam logic [3:0] KEY_CLEAR   = 4'd11;
    localparam logic [3:0] KEY_SET     = 4'd12;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] WRONG_SAT   = 4'd9;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    // The wrong-attempt counter is shown on a single 7-seg digit, so it stops at 9.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= WRONG_SAT) ? WRONG_SAT : v + 4'd1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by the OPEN and LOCKOUT states. A load of N followed by
// enabled cycles raises done on the Nth enabled cycle, so the owner leaves after N cycles.
module lock_timer #(
    parameter int TMR_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // A count of 0 also reports done so a zero load can never stall the FSM.
    assign done = en && !load && (cnt_q <= TMR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: collects four keypad digits, checks them against the
// stored code, drives unlock/alarm and feeds the 7-seg multiplexer.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int          MAX_WRONG    = 3,
    parameter int          OPEN_CYCLES  = 50_000_000,
    parameter int          LOCK_CYCLES  = 250_000_000,
    parameter int          TMR_W        = 28,
    parameter logic [15:0] DEFAULT_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] seg_d1,
    output logic [3:0] seg_d2,
    output logic [3:0] seg_d3,
    output logic [3:0] seg_d4,
    output logic [3:0] wrong_cnt,
    output logic       unlocked,
    output logic       alarm
);

    localparam logic [TMR_W-1:0] OPEN_LOAD   = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCK_CYCLES);
    localparam logic [3:0]       MAX_WRONG_L = 4'(MAX_WRONG);
    localparam logic [15:0]      ALL_BLANK   = {4{DIGIT_BLANK}};

    logic [2:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [3:0][3:0]  dig_q, dig_d;      // dig_q[0] is the first digit entered
    logic [15:0]      code_q, code_d;
    logic [3:0]       wrong_q, wrong_d;
    logic             unlocked_q, unlocked_d;
    logic             alarm_q, alarm_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_done;

    logic             k_digit, k_enter, k_clear, k_set;
    logic             ptr_full;
    logic [15:0]      entered;
    logic [3:0]       wrong_inc;

    assign k_digit   = key_valid && is_digit(key_code);
    assign k_enter   = key_valid && (key_code == KEY_ENTER);
    assign k_clear   = key_valid && (key_code == KEY_CLEAR);
    assign k_set     = key_valid && (key_code == KEY_SET);
    assign ptr_full  = (ptr_q == 3'd4);
    assign entered   = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
    assign wrong_inc = sat_inc(wrong_q);

    lock_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .done    (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dig_d      = dig_q;
        code_d     = code_q;
        wrong_d    = wrong_q;
        unlocked_d = unlocked_q;
        alarm_d    = alarm_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (k_digit) begin
                    if (!ptr_full) begin
                        dig_d[ptr_q[1:0]] = key_code;
                        ptr_d             = ptr_q + 3'd1;
                        state_d           = ST_ENTRY;
                    end
                end else if (k_clear) begin
                    dig_d   = ALL_BLANK;
                    ptr_d   = 3'd0;
                    state_d = ST_IDLE;
                end else if (k_enter && ptr_full) begin
                    state_d = ST_CHECK;
                end
            end

            // Single evaluation cycle; any key arriving here is dropped.
            ST_CHECK: begin
                dig_d = ALL_BLANK;
                ptr_d = 3'd0;
                if (entered == code_q) begin
                    state_d    = ST_OPEN;
                    unlocked_d = 1'b1;
                    wrong_d    = 4'd0;
                    tmr_load   = 1'b1;
                    tmr_val    = OPEN_LOAD;
                end else begin
                    wrong_d = wrong_inc;
                    if (wrong_inc >= MAX_WRONG_L) begin
                        state_d  = ST_LOCKOUT;
                        alarm_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            // Expiry is tested first so a key in the same cycle is lost.
            ST_OPEN: begin
                tmr_en = 1'b1;
                if (tmr_done || k_clear) begin
                    state_d    = ST_IDLE;
                    unlocked_d = 1'b0;
                end else if (k_set) begin
                    state_d = ST_SETPW;
                    dig_d   = ALL_BLANK;
                    ptr_d   = 3'd0;
                end
            end

            ST_SETPW: begin
                if (k_digit) begin
                    if (!ptr_full) begin
                        dig_d[ptr_q[1:0]] = key_code;
                        ptr_d             = ptr_q + 3'd1;
                    end
                end else if (k_clear || (k_enter && ptr_full)) begin
                    if (k_enter) begin
                        code_d = entered;
                    end
                    state_d    = ST_IDLE;
                    unlocked_d = 1'b0;
                    dig_d      = ALL_BLANK;
                    ptr_d      = 3'd0;
                end
            end

            ST_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    alarm_d = 1'b0;
                    wrong_d = 4'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            dig_q      <= ALL_BLANK;
            code_q     <= DEFAULT_CODE;
            wrong_q    <= 4'd0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dig_q      <= dig_d;
            code_q     <= code_d;
            wrong_q    <= wrong_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign seg_d1    = dig_q[0];
    assign seg_d2    = dig_q[1];
    assign seg_d3    = dig_q[2];
    assign seg_d4    = dig_q[3];
    assign wrong_cnt = wrong_q;
    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Scenario bench for lock_ctrl: expected output snapshots are queued as each key is
// driven and compared against the captured DUT outputs when a scenario drains.
module tb_lock_ctrl;

    localparam logic [3:0]  K_ENTER = 4'd10;
    localparam logic [3:0]  K_CLEAR = 4'd11;
    localparam logic [3:0]  K_SET   = 4'd12;
    localparam logic [15:0] BL      = 16'hFFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] seg_d1, seg_d2, seg_d3, seg_d4;
    logic [3:0] wrong_cnt;
    logic       unlocked, alarm;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];

    lock_ctrl #(
        .MAX_WRONG   (3),
        .OPEN_CYCLES (20),
        .LOCK_CYCLES (30),
        .TMR_W       (28),
        .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .seg_d1   (seg_d1),
        .seg_d2   (seg_d2),
        .seg_d3   (seg_d3),
        .seg_d4   (seg_d4),
        .wrong_cnt(wrong_cnt),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] observed();
        return {seg_d1, seg_d2, seg_d3, seg_d4, wrong_cnt, unlocked, alarm};
    endfunction

    function automatic logic [21:0] ex(input logic [15:0] d, input logic [3:0] w,
                                       input logic u, input logic a);
        return {d, w, u, a};
    endfunction

    // One cycle of stimulus: queue the expected snapshot, then capture the DUT after the edge.
    task automatic drive(input logic v, input logic [3:0] k, input logic [21:0] e);
        @(negedge clk);
        key_valid = v;
        key_code  = k;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back(observed());
        key_valid = 1'b0;
    endtask

    // Four digits then ENTER from IDLE; the display fills left to right.
    task automatic enter4(input logic [15:0] c, input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c[15-4*i -: 4], ex(c | (BL >> (4*(i+1))), w, 1'b0, 1'b0));
        end
        drive(1'b1, K_ENTER, ex(c, w, 1'b0, 1'b0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== ex(BL, 4'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", observed(), ex(BL, 4'd0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unlock();
        logic [21:0] e, o;
        int n = 0;
        enter4(16'h1234, 4'd0);
        drive(1'b1, 4'd7, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd5, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd13, ex(BL, 4'd0, 1'b1, 1'b0));
        for (int i = 0; i < 17; i++) drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_SET, ex(BL, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd1, ex(16'h1FFF, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL unlock[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_partial();
        logic [21:0] e, o;
        int n = 0;
        drive(1'b1, 4'd1, ex(16'h1FFF, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd2, ex(16'h12FF, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd3, ex(16'h123F, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_ENTER, ex(16'h123F, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_SET, ex(16'h123F, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd14, ex(16'h123F, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd9, ex(16'h1239, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd5, ex(16'h1239, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd15, ex(16'h1239, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd13, ex(BL, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_ENTER, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL partial[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_setpw_clear();
        logic [21:0] e, o;
        int n = 0;
        enter4(16'h1234, 4'd0);
        drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_SET, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd9, ex(16'h9FFF, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd9, ex(16'h99FF, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_ENTER, ex(16'h99FF, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        enter4(16'h1234, 4'd0);
        drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL setpw_clear[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_lockout();
        logic [21:0] e, o;
        logic [3:0] junk [5];
        int n = 0;
        junk[0] = 4'd1; junk[1] = K_ENTER; junk[2] = K_CLEAR; junk[3] = K_SET; junk[4] = 4'd15;
        for (int a = 1; a <= 3; a++) begin
            enter4(16'h0000, 4'(a - 1));
            drive(1'b0, 4'd0, ex(BL, 4'(a), 1'b0, (a == 3)));
        end
        for (int i = 0; i < 29; i++) drive(1'b1, junk[i % 5], ex(BL, 4'd3, 1'b0, 1'b1));
        drive(1'b1, 4'd8, ex(BL, 4'd0, 1'b0, 1'b0));
        drive(1'b1, 4'd8, ex(16'h8FFF, 4'd0, 1'b0, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lockout[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_setpw();
        logic [21:0] e, o;
        int n = 0;
        enter4(16'h1234, 4'd0);
        drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_SET, ex(BL, 4'd0, 1'b1, 1'b0));
        for (int i = 0; i < 25; i++) drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd14, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd5, ex(16'h5FFF, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd6, ex(16'h56FF, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd7, ex(16'h567F, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd8, ex(16'h5678, 4'd0, 1'b1, 1'b0));
        drive(1'b1, 4'd9, ex(16'h5678, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_ENTER, ex(BL, 4'd0, 1'b0, 1'b0));
        enter4(16'h1234, 4'd0);
        drive(1'b0, 4'd0, ex(BL, 4'd1, 1'b0, 1'b0));
        enter4(16'h5678, 4'd1);
        drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL setpw[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    // Code is 5678 on entry; reset lands in the middle of a lockout.
    task automatic test_reset_mid();
        logic [21:0] e, o;
        int n = 0;
        for (int a = 1; a <= 3; a++) begin
            enter4(16'h0000, 4'(a - 1));
            drive(1'b0, 4'd0, ex(BL, 4'(a), 1'b0, (a == 3)));
        end
        drive(1'b1, 4'd1, ex(BL, 4'd3, 1'b0, 1'b1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== ex(BL, 4'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", observed(), ex(BL, 4'd0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        enter4(16'h1234, 4'd0);
        drive(1'b0, 4'd0, ex(BL, 4'd0, 1'b1, 1'b0));
        drive(1'b1, K_CLEAR, ex(BL, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got %h required %h", n, o, e);
            end
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unlock();
        test_partial();
        test_setpw_clear();
        test_lockout();
        test_setpw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
